// File: rtl/ov7670_sccb_responder_pkg.sv
// ov7670_sccb_pkg: shared definitions for the OV7670-style SCCB register
// responder. Holds the FSM state enum, the default device write address
// and the COM7 soft-reset register location/bit.
// Optional feature macro: SCCB_READ_EN (adds the READ_DATA state).
package ov7670_sccb_pkg;

   localparam logic [7:0] DEFAULT_DEVICE_ID = 8'h42;
   localparam logic [7:0] COM7_ADDR         = 8'h12;
   localparam int         COM7_RESET_BIT    = 7;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ID,
      ST_ACK_ID,
      ST_SUBADDR,
      ST_ACK_SUB,
      ST_DATA,
      ST_ACK_DATA,
      ST_IGNORE
`ifdef SCCB_READ_EN
      , ST_READ_DATA
`endif
   } sccb_state_e;

endpackage

// File: rtl/ov7670_sccb_responder_if.sv
// ov7670_sccb_responder_if: the two-wire SCCB bus as seen by the responder.
//   sioc     - SCCB clock driven by the master
//   siod_in  - SIOD level at the pad (wired-AND of all drivers)
//   siod_oe  - responder pull-down enable (1 = drive SIOD low)
interface ov7670_sccb_responder_if;
   logic sioc;
   logic siod_in;
   logic siod_oe;

   modport master (output sioc, output siod_in, input siod_oe);
   modport slave  (input sioc, input siod_in, output siod_oe);
endinterface

// File: rtl/ov7670_sccb_responder_sync.sv
// sccb_line_sync: brings the asynchronous SCCB lines into the clk domain
// and derives bus events from the synchronized levels.
//   clk, reset        - system clock, synchronous active-high reset
//   sioc, siod_in     - raw SCCB lines
//   sda               - synchronized SIOD level
//   scl_rise/scl_fall - one-cycle SIOC edge strobes
//   start/stop        - one-cycle START / STOP condition strobes
module sccb_line_sync (
   input  logic clk,
   input  logic reset,
   input  logic sioc,
   input  logic siod_in,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   logic [1:0] scl_ff, sda_ff;
   logic       scl, scl_d, sda_d;

   // Idle bus level is high on both lines; resetting to 1 avoids a
   // spurious START right after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_ff <= 2'b11;
         sda_ff <= 2'b11;
         scl_d  <= 1'b1;
         sda_d  <= 1'b1;
      end else begin
         scl_ff <= {scl_ff[0], sioc};
         sda_ff <= {sda_ff[0], siod_in};
         scl_d  <= scl_ff[1];
         sda_d  <= sda_ff[1];
      end
   end

   assign scl      = scl_ff[1];
   assign sda      = sda_ff[1];
   assign scl_rise = scl & ~scl_d;
   assign scl_fall = ~scl & scl_d;
   // SIOD may only move while SIOC is high for START/STOP; require SIOC
   // high on both sides of the SIOD change.
   assign start    = scl & scl_d & sda_d & ~sda;
   assign stop     = scl & scl_d & ~sda_d & sda;

endmodule

// File: rtl/ov7670_sccb_responder.sv
// ov7670_sccb_responder: SCCB (I2C-like) slave with a 256 x 8 register file.
// A write transaction is ID / sub-address / one data byte; later bytes
// are NACKed and dropped. Writing COM7 with bit7 set pulses soft_reset and
// wipes the register file over the following 256 cycles.
// Optional macro SCCB_READ_EN: ID == DEVICE_ID|1 is ACKed and regfile[ptr]
// is shifted out MSB first.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   bus (slave modport)   - sioc / siod_in / siod_oe
//   reg_wr_en/addr/data   - one-cycle strobe per committed write
//   soft_reset            - one-cycle pulse on COM7 reset write
//   rd_addr / rd_data     - debug read port, 1-cycle registered latency
//   busy                  - transaction in progress (START..STOP/reset)
module ov7670_sccb_responder #(
   parameter logic [7:0] DEVICE_ID = ov7670_sccb_pkg::DEFAULT_DEVICE_ID,
   parameter logic [7:0] COM7_ADDR = ov7670_sccb_pkg::COM7_ADDR
) (
   input  logic                          clk,
   input  logic                          reset,
   ov7670_sccb_responder_if.slave        bus,
   output logic                          reg_wr_en,
   output logic [7:0]                    reg_wr_addr,
   output logic [7:0]                    reg_wr_data,
   output logic                          soft_reset,
   input  logic [7:0]                    rd_addr,
   output logic [7:0]                    rd_data,
   output logic                          busy
);
   import ov7670_sccb_pkg::*;

   logic        sda, scl_rise, scl_fall, start, stop;
   sccb_state_e state;
   logic [2:0]  bitcnt;
   logic [6:0]  shreg;
   logic [7:0]  byte_full;
   logic [7:0]  ptr;
   logic        oe, ack_on;
   logic        clearing;
   logic [7:0]  clr_cnt;
   logic        in_byte, byte_done, id_ok, wr_commit;
   logic [7:0]  regfile [256];
`ifdef SCCB_READ_EN
   logic        rd_mode, id_rd;
   logic [6:0]  rd_shift;
`endif

   sccb_line_sync u_sync (
      .clk      (clk),
      .reset    (reset),
      .sioc     (bus.sioc),
      .siod_in  (bus.siod_in),
      .sda      (sda),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop)
   );

   assign bus.siod_oe = oe;
   assign byte_full   = {shreg, sda};
   assign in_byte     = (state == ST_ID) || (state == ST_SUBADDR) || (state == ST_DATA);
   assign byte_done   = in_byte && scl_rise && (bitcnt == 3'd7);

   // While the wipe is running the device refuses new transactions.
`ifdef SCCB_READ_EN
   assign id_rd = (byte_full == (DEVICE_ID | 8'h01));
   assign id_ok = ((byte_full == DEVICE_ID) || id_rd) && !clearing;
`else
   assign id_ok = (byte_full == DEVICE_ID) && !clearing;
`endif

   assign wr_commit = !reset && !start && !stop && byte_done &&
                      (state == ST_DATA) && !clearing;

   // Register file has no reset: contents survive the reset input.
   always_ff @(posedge clk) begin
      if (clearing)
         regfile[clr_cnt] <= 8'h00;
      else if (wr_commit)
         regfile[ptr] <= byte_full;
   end

   always_ff @(posedge clk) begin
      if (reset) rd_data <= 8'h00;
      else       rd_data <= regfile[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         bitcnt      <= 3'd0;
         shreg       <= 7'd0;
         ptr         <= 8'h00;
         oe          <= 1'b0;
         ack_on      <= 1'b0;
         reg_wr_en   <= 1'b0;
         reg_wr_addr <= 8'h00;
         reg_wr_data <= 8'h00;
         soft_reset  <= 1'b0;
         busy        <= 1'b0;
         clearing    <= 1'b0;
         clr_cnt     <= 8'h00;
`ifdef SCCB_READ_EN
         rd_mode     <= 1'b0;
         rd_shift    <= 7'd0;
`endif
      end else begin
         reg_wr_en  <= 1'b0;
         soft_reset <= 1'b0;

         if (clearing) begin
            clr_cnt <= clr_cnt + 8'd1;
            if (clr_cnt == 8'hFF) clearing <= 1'b0;
         end

         if (start) begin
            state  <= ST_ID;
            bitcnt <= 3'd0;
            oe     <= 1'b0;
            ack_on <= 1'b0;
            busy   <= 1'b1;
`ifdef SCCB_READ_EN
            rd_mode <= 1'b0;
`endif
         end else if (stop) begin
            state  <= ST_IDLE;
            oe     <= 1'b0;
            ack_on <= 1'b0;
            busy   <= 1'b0;
         end else begin
            if (in_byte && scl_rise) begin
               shreg  <= byte_full[6:0];
               bitcnt <= bitcnt + 3'd1;
            end

            case (state)
               ST_ID: if (byte_done) begin
                  if (id_ok) state <= ST_ACK_ID;
                  else       state <= ST_IGNORE;
`ifdef SCCB_READ_EN
                  rd_mode <= id_rd;
`endif
               end

               ST_SUBADDR: if (byte_done) begin
                  ptr   <= byte_full;
                  state <= ST_ACK_SUB;
               end

               ST_DATA: if (byte_done) begin
                  if (clearing) begin
                     state <= ST_IGNORE;
                  end else begin
                     reg_wr_en   <= 1'b1;
                     reg_wr_addr <= ptr;
                     reg_wr_data <= byte_full;
                     state       <= ST_ACK_DATA;
                     if (ptr == COM7_ADDR && byte_full[COM7_RESET_BIT]) begin
                        soft_reset <= 1'b1;
                        clearing   <= 1'b1;
                        clr_cnt    <= 8'h00;
                     end
                  end
               end

               // First SIOC fall after bit 8 grabs the line, the next
               // fall lets it go and moves on.
               ST_ACK_ID, ST_ACK_SUB, ST_ACK_DATA: if (scl_fall) begin
                  if (!ack_on) begin
                     oe     <= 1'b1;
                     ack_on <= 1'b1;
                  end else begin
                     ack_on <= 1'b0;
                     bitcnt <= 3'd0;
                     oe     <= 1'b0;
                     if (state == ST_ACK_ID) begin
`ifdef SCCB_READ_EN
                        if (rd_mode) begin
                           // Hand straight over to the MSB of read data.
                           state    <= ST_READ_DATA;
                           oe       <= ~regfile[ptr][7];
                           rd_shift <= regfile[ptr][6:0];
                        end else begin
                           state <= ST_SUBADDR;
                        end
`else
                        state <= ST_SUBADDR;
`endif
                     end else if (state == ST_ACK_SUB) begin
                        state <= ST_DATA;
                     end else begin
                        state <= ST_IGNORE;
                     end
                  end
               end

`ifdef SCCB_READ_EN
               // Seven more bits follow on successive falls; the eighth
               // fall releases SIOD for the master's NACK.
               ST_READ_DATA: if (scl_fall) begin
                  if (bitcnt == 3'd7) begin
                     oe    <= 1'b0;
                     state <= ST_IGNORE;
                  end else begin
                     oe       <= ~rd_shift[6];
                     rd_shift <= {rd_shift[5:0], 1'b0};
                     bitcnt   <= bitcnt + 3'd1;
                  end
               end
`endif

               ST_IDLE, ST_IGNORE: ;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
